// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Per-register in-flight write tracker that stalls decode on RAW
//            hazards or counter saturation, with stall and underflow stats.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_wb_en,
    input  logic [3:0]  issue_dest,
    input  logic [3:0]  issue_src1,
    input  logic [3:0]  issue_src2,
    input  logic        issue_two_src,
    input  logic        flush,
    input  logic        wb_wb_en,
    input  logic [3:0]  wb_dest,
    output logic        stall,
    output logic        issue_accept,
    output logic [15:0] pending_mask,
    output logic [5:0]  inflight_total,
    output logic [15:0] stall_cycles,
    output logic        underflow_err
);

    localparam int         C_NUM_REGS  = 16;
    localparam logic [1:0] C_CNT_MAX   = 2'd3;
    localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

    logic [C_NUM_REGS-1:0][1:0] r_cnt;
    logic [C_NUM_REGS-1:0][1:0] w_cnt_next;
    logic [15:0]                r_pending_mask;
    logic [5:0]                 r_inflight_total;
    logic [15:0]                r_stall_cycles;
    logic                       r_underflow_err;

    logic w_hazard;
    logic w_sat;
    logic w_inc;
    logic w_dec;
    logic w_underflow;

    // Hazard detection looks only at registered counts, so a write-back
    // landing this cycle releases the stall one cycle later.
    assign w_hazard     = (r_cnt[issue_src1] != 2'd0) |
                          (issue_two_src & (r_cnt[issue_src2] != 2'd0));
    assign w_sat        = issue_wb_en & (r_cnt[issue_dest] == C_CNT_MAX);
    assign stall        = issue_valid & ~flush & (w_hazard | w_sat);
    assign issue_accept = issue_valid & ~flush & ~stall;

    assign w_inc       = issue_accept & issue_wb_en;
    assign w_dec       = wb_wb_en & (r_cnt[wb_dest] != 2'd0);
    assign w_underflow = wb_wb_en & (r_cnt[wb_dest] == 2'd0);

    generate
        for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_cnt
            logic w_hit_inc;
            logic w_hit_dec;
            assign w_hit_inc = w_inc & (issue_dest == 4'(gi));
            assign w_hit_dec = w_dec & (wb_dest == 4'(gi));
            assign w_cnt_next[gi] = (w_hit_inc & ~w_hit_dec) ? r_cnt[gi] + 2'd1 :
                                    (w_hit_dec & ~w_hit_inc) ? r_cnt[gi] - 2'd1 :
                                    r_cnt[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt            <= '0;
            r_pending_mask   <= '0;
            r_inflight_total <= '0;
            r_stall_cycles   <= '0;
            r_underflow_err  <= 1'b0;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_cnt[i]          <= w_cnt_next[i];
                r_pending_mask[i] <= (w_cnt_next[i] != 2'd0);
            end
            // Same-register inc and dec cancel here exactly as in the counter.
            r_inflight_total <= r_inflight_total + {5'd0, w_inc} - {5'd0, w_dec};
            if (stall && (r_stall_cycles != C_STALL_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_underflow) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign pending_mask   = r_pending_mask;
    assign inflight_total = r_inflight_total;
    assign stall_cycles   = r_stall_cycles;
    assign underflow_err  = r_underflow_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed scoreboard bench for hazard_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int K_STALL  = 0;
    localparam int K_ACCEPT = 1;
    localparam int K_MASK   = 2;
    localparam int K_TOTAL  = 3;
    localparam int K_SCYC   = 4;
    localparam int K_UFLOW  = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_wb_en;
    logic [3:0]  issue_dest;
    logic [3:0]  issue_src1;
    logic [3:0]  issue_src2;
    logic        issue_two_src;
    logic        flush;
    logic        wb_wb_en;
    logic [3:0]  wb_dest;
    logic        stall;
    logic        issue_accept;
    logic [15:0] pending_mask;
    logic [5:0]  inflight_total;
    logic [15:0] stall_cycles;
    logic        underflow_err;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_wb_en    (issue_wb_en),
        .issue_dest     (issue_dest),
        .issue_src1     (issue_src1),
        .issue_src2     (issue_src2),
        .issue_two_src  (issue_two_src),
        .flush          (flush),
        .wb_wb_en       (wb_wb_en),
        .wb_dest        (wb_dest),
        .stall          (stall),
        .issue_accept   (issue_accept),
        .pending_mask   (pending_mask),
        .inflight_total (inflight_total),
        .stall_cycles   (stall_cycles),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K_STALL:  return {15'd0, stall};
            K_ACCEPT: return {15'd0, issue_accept};
            K_MASK:   return pending_mask;
            K_TOTAL:  return {10'd0, inflight_total};
            K_SCYC:   return stall_cycles;
            default:  return {15'd0, underflow_err};
        endcase
    endfunction

    // Monitor: every falling edge retires the expectations due this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [15:0] a;
            e = exp_q.pop_front();
            a = actual(e.kind);
            n_checks++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
            end else if (a !== e.val) begin
                n_fail++;
                $display("FAIL %s: cycle %0d got 0x%04h expected 0x%04h", e.name, cyc, a, e.val);
            end
        end
    end

    task automatic expect_at(input int off, input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Advance one cycle and drive a full input vector.
    task automatic step(input logic r, input logic iv, input logic wen, input logic [3:0] dst,
                        input logic [3:0] s1, input logic [3:0] s2, input logic two,
                        input logic fl, input logic wbe, input logic [3:0] wbd);
        @(posedge clk);
        #1;
        rst = r; issue_valid = iv; issue_wb_en = wen; issue_dest = dst;
        issue_src1 = s1; issue_src2 = s2; issue_two_src = two;
        flush = fl; wb_wb_en = wbe; wb_dest = wbd;
    endtask

    task automatic issue(input logic [3:0] dst, input logic [3:0] s1);
        step(1'b0, 1'b1, 1'b1, dst, s1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic wb_only(input logic [3:0] wbd);
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, wbd);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = '0;
        issue_src1 = '0; issue_src2 = '0; issue_two_src = 1'b0;
        flush = 1'b0; wb_wb_en = 1'b0; wb_dest = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_at(0, K_STALL, 16'd0, "rst_stall");
        expect_at(0, K_MASK,  16'h0000, "rst_mask");
        expect_at(0, K_TOTAL, 16'd0, "rst_total");
        expect_at(0, K_SCYC,  16'd0, "rst_scyc");
        expect_at(0, K_UFLOW, 16'd0, "rst_uflow");

        // RAW hazard on R3, released one cycle after its write-back
        issue(4'd3, 4'd0);
        expect_at(0, K_ACCEPT, 16'd1, "raw_first_accept");
        expect_at(1, K_MASK,   16'h0008, "raw_mask_r3");
        expect_at(1, K_TOTAL,  16'd1, "raw_total1");
        issue(4'd4, 4'd3);
        expect_at(0, K_STALL,  16'd1, "raw_stall");
        expect_at(0, K_ACCEPT, 16'd0, "raw_no_accept");
        expect_at(1, K_SCYC,   16'd1, "raw_scyc1");
        step(1'b0, 1'b1, 1'b1, 4'd4, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3);
        expect_at(0, K_STALL,  16'd1, "raw_stall_same_cycle_wb");
        expect_at(1, K_MASK,   16'h0000, "raw_mask_cleared");
        expect_at(1, K_TOTAL,  16'd0, "raw_total0");
        expect_at(1, K_SCYC,   16'd2, "raw_scyc2");
        issue(4'd4, 4'd3);
        expect_at(0, K_STALL,  16'd0, "raw_released");
        expect_at(0, K_ACCEPT, 16'd1, "raw_released_accept");
        expect_at(1, K_MASK,   16'h0010, "raw_mask_r4");
        wb_only(4'd4);
        expect_at(1, K_TOTAL,  16'd0, "raw_drain");

        // Counter saturation on R5
        issue(4'd5, 4'd0);
        issue(4'd5, 4'd0);
        issue(4'd5, 4'd0);
        expect_at(0, K_ACCEPT, 16'd1, "sat_third_accept");
        expect_at(1, K_MASK,   16'h0020, "sat_mask");
        expect_at(1, K_TOTAL,  16'd3, "sat_total3");
        issue(4'd5, 4'd0);
        expect_at(0, K_STALL,  16'd1, "sat_stall");
        expect_at(0, K_ACCEPT, 16'd0, "sat_no_accept");
        expect_at(1, K_TOTAL,  16'd3, "sat_total_held");
        expect_at(1, K_SCYC,   16'd3, "sat_scyc3");
        wb_only(4'd5);
        wb_only(4'd5);
        wb_only(4'd5);
        expect_at(1, K_TOTAL,  16'd0, "sat_drain_total");
        expect_at(1, K_MASK,   16'h0000, "sat_drain_mask");

        // Simultaneous issue and write-back to R7
        issue(4'd7, 4'd0);
        expect_at(1, K_TOTAL,  16'd1, "same_pre_total");
        step(1'b0, 1'b1, 1'b1, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7);
        expect_at(0, K_ACCEPT, 16'd1, "same_accept");
        expect_at(1, K_TOTAL,  16'd1, "same_total_unchanged");
        expect_at(1, K_MASK,   16'h0080, "same_mask_r7");
        wb_only(4'd7);
        expect_at(1, K_TOTAL,  16'd0, "same_drain");
        expect_at(1, K_UFLOW,  16'd0, "no_uflow_yet");

        // Underflow on empty R9, sticky until reset
        issue(4'd1, 4'd0);
        expect_at(1, K_MASK,   16'h0002, "uf_pre_mask");
        wb_only(4'd9);
        expect_at(1, K_UFLOW,  16'd1, "uf_set");
        expect_at(1, K_MASK,   16'h0002, "uf_mask_unchanged");
        expect_at(1, K_TOTAL,  16'd1, "uf_total_unchanged");
        idle();
        expect_at(1, K_UFLOW,  16'd1, "uf_sticky");

        // Flush cancels issue; same-cycle write-back still applies
        step(1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        expect_at(0, K_STALL,  16'd0, "flush_no_stall");
        expect_at(0, K_ACCEPT, 16'd0, "flush_no_accept");
        expect_at(1, K_MASK,   16'h0002, "flush_mask_unchanged");
        expect_at(1, K_SCYC,   16'd3, "flush_scyc_unchanged");
        step(1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1);
        expect_at(1, K_MASK,   16'h0000, "flush_wb_applied");
        expect_at(1, K_TOTAL,  16'd0, "flush_wb_total");

        // Second-source hazard, then reset with four registers in flight
        issue(4'd10, 4'd0);
        issue(4'd11, 4'd0);
        issue(4'd12, 4'd0);
        issue(4'd13, 4'd0);
        expect_at(1, K_MASK,   16'h3C00, "fill_mask");
        expect_at(1, K_TOTAL,  16'd4, "fill_total");
        step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd10, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_at(0, K_STALL,  16'd0, "src2_ignored");
        step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd10, 1'b1, 1'b0, 1'b0, 4'd0);
        expect_at(0, K_STALL,  16'd1, "src2_hazard");
        expect_at(1, K_SCYC,   16'd4, "src2_scyc4");
        step(1'b1, 1'b1, 1'b1, 4'd14, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_at(0, K_STALL,  16'd0, "rst_cycle_stall");
        expect_at(1, K_MASK,   16'h0000, "rst2_mask");
        expect_at(1, K_TOTAL,  16'd0, "rst2_total");
        expect_at(1, K_SCYC,   16'd0, "rst2_scyc");
        expect_at(1, K_UFLOW,  16'd0, "rst2_uflow");
        idle();
        expect_at(0, K_STALL,  16'd0, "post_rst_stall");
        expect_at(1, K_MASK,   16'h0000, "post_rst_mask");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port issue_valid, input, 1, decode stage presents an instruction this cycle.
REQ-004 SHALL have port issue_wb_en, input, 1, the presented instruction writes a register.
REQ-005 SHALL have port issue_dest, input, 4, destination register of the presented instruction.
REQ-006 SHALL have ports issue_src1 and issue_src2, input, 4 each, source registers of the presented instruction.
REQ-007 SHALL have port issue_two_src, input, 1; 1 means issue_src2 is used.
REQ-008 SHALL have port flush, input, 1, cancels the presented instruction this cycle.
REQ-009 SHALL have port wb_wb_en, input, 1, a write-back to wb_dest completes this cycle.
REQ-010 SHALL have port wb_dest, input, 4, write-back destination register.
REQ-011 SHALL have port stall, output, 1, combinational; holds decode this cycle.
REQ-012 SHALL have port issue_accept, output, 1, combinational; equals issue_valid & ~flush & ~stall.
REQ-013 SHALL have port pending_mask, output, 16, registered; bit r is 1 iff the in-flight count of register r is non-zero.
REQ-014 SHALL have port inflight_total, output, 6, registered; sum of all in-flight counts.
REQ-015 SHALL have port stall_cycles, output, 16, registered; saturating count of cycles with stall=1 and issue_valid=1.
REQ-016 SHALL have port underflow_err, output, 1, registered; sticky error flag.

Function
REQ-017 SHALL keep one 2-bit in-flight counter per register 0..15; range 0..3.
REQ-018 SHALL compute hazard = cnt[issue_src1]!=0, OR (issue_two_src AND cnt[issue_src2]!=0).
REQ-019 SHALL compute sat = issue_wb_en AND cnt[issue_dest]==3.
REQ-020 SHALL drive stall = issue_valid AND ~flush AND (hazard OR sat); stall SHALL be 0 when flush=1.
REQ-021 SHALL compute stall from registered counters only; a same-cycle write-back SHALL NOT clear a stall (one-cycle conservative latency).
REQ-022 SHALL set inc = issue_accept AND issue_wb_en, targeting issue_dest.
REQ-023 SHALL set dec = wb_wb_en AND cnt[wb_dest]!=0, targeting wb_dest.
REQ-024 SHALL update each counter next edge: +1 if only inc hits it, -1 if only dec hits it, unchanged if both or neither hit it.
REQ-025 SHALL set underflow_err on wb_wb_en with cnt[wb_dest]==0; that counter SHALL stay 0; the flag SHALL hold until rst.
REQ-026 SHALL update inflight_total next edge by +inc -dec; it SHALL equal the sum of the counters at all times (max 48).
REQ-027 SHALL register pending_mask from the next counter values, so it is valid in the same cycle as the updated counters.
REQ-028 SHALL increment stall_cycles when stall=1; it SHALL saturate at 16'hFFFF.
REQ-029 SHALL leave all counters unchanged by a flushed issue, while applying a write-back in the same cycle.

Reset
REQ-030 SHALL, on rst=1 at a rising edge, clear all counters, pending_mask=0, inflight_total=0, stall_cycles=0 and underflow_err=0.
REQ-031 SHALL give rst priority over every same-cycle issue and write-back; those events SHALL be discarded.
REQ-032 SHALL, while rst=1, still drive stall and issue_accept combinationally from the cleared state; stall=0 after the first reset edge.

Verification
REQ-033 SHALL pass: issue dest=R3 with wb_en; next cycle issue src1=R3 -> stall=1, issue_accept=0; after wb_wb_en dest=R3, stall=0 the following cycle; stall_cycles>=1.
REQ-034 SHALL pass: three accepted issues to R5 with no write-back, then a fourth issue to R5 -> stall=1 (sat); pending_mask[5]=1; inflight_total=3.
REQ-035 SHALL pass: in one cycle, accepted issue to R7 and wb to R7 with cnt[R7]=1 -> cnt[R7] stays 1; inflight_total unchanged.
REQ-036 SHALL pass: wb_wb_en dest=R9 with cnt[R9]=0 -> underflow_err=1 next cycle, pending_mask unchanged; the flag persists until rst.
REQ-037 SHALL pass: flush=1 with issue_valid=1 dest=R2 and src1 pending -> stall=0, issue_accept=0, cnt[R2] unchanged.
REQ-038 SHALL pass: rst asserted with 4 registers in flight and a same-cycle issue -> next cycle pending_mask=0, inflight_total=0, stall_cycles=0.
